// File: rtl/movement_ctrl_if.sv
// Button, detector and position/room signals shared between the hero
// movement controller and whatever drives or observes it.
interface movement_ctrl_if #(
    parameter int POS_W     = 10,
    parameter int NUM_ROOMS = 16
);
    localparam int ROOM_W = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1;

    logic                 u_arr;
    logic                 d_arr;
    logic                 l_arr;
    logic                 r_arr;
    logic                 collision;
    logic                 coll_miner;
    logic [NUM_ROOMS-1:0] death_flag;
    logic                 win_flag;
    logic [POS_W-1:0]     char_pos_x;
    logic [POS_W-1:0]     char_pos_y;
    logic [NUM_ROOMS-1:0] active;
    logic [ROOM_W-1:0]    room_idx;
    logic                 room_change;
    logic                 won;

    // Stimulus side: buttons and detectors out, position and room in.
    modport master (
        output u_arr, d_arr, l_arr, r_arr, collision, coll_miner, death_flag, win_flag,
        input  char_pos_x, char_pos_y, active, room_idx, room_change, won
    );

    // Controller side.
    modport slave (
        input  u_arr, d_arr, l_arr, r_arr, collision, coll_miner, death_flag, win_flag,
        output char_pos_x, char_pos_y, active, room_idx, room_change, won
    );
endinterface

// File: rtl/movement_ctrl.sv
// Hero movement controller: steps the character one axis at a time from
// active-low arrows, rolls back on wall collision, walks between rooms at
// the top/bottom edges, respawns on death or miner rescue, freezes on win.
module movement_ctrl #(
    parameter int POS_W       = 10,
    parameter int NUM_ROOMS   = 16,
    parameter int INIT_X      = 175,
    parameter int INIT_Y      = 100,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 630,
    parameter int Y_TOP       = 40,
    parameter int Y_BOT       = 400,
    parameter int ENTRY_TOP   = 50,
    parameter int ENTRY_BOT   = 350,
    parameter int STEP        = 1,
    parameter int MOVE_DIV    = 1,
    parameter int RESPAWN_CYC = 4,
    parameter logic [NUM_ROOMS-1:0] DOWN_EXIT = '1,
    parameter logic [NUM_ROOMS-1:0] UP_EXIT   = ~NUM_ROOMS'(1),
    parameter logic [NUM_ROOMS-1:0] MINER_ADV = NUM_ROOMS'(34)
) (
    input  logic          clk_char,
    input  logic          rst_n,
    movement_ctrl_if.slave bus
);
    localparam int ROOM_W = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1;
    localparam int TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int HOLD_W = (RESPAWN_CYC > 0) ? $clog2(RESPAWN_CYC + 1) : 1;

    localparam logic [POS_W-1:0]  INIT_X_P    = POS_W'(INIT_X);
    localparam logic [POS_W-1:0]  INIT_Y_P    = POS_W'(INIT_Y);
    localparam logic [POS_W-1:0]  X_MIN_P     = POS_W'(X_MIN);
    localparam logic [POS_W-1:0]  X_MAX_P     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]  Y_TOP_P     = POS_W'(Y_TOP);
    localparam logic [POS_W-1:0]  Y_BOT_P     = POS_W'(Y_BOT);
    localparam logic [POS_W-1:0]  ENTRY_TOP_P = POS_W'(ENTRY_TOP);
    localparam logic [POS_W-1:0]  ENTRY_BOT_P = POS_W'(ENTRY_BOT);
    localparam logic [POS_W-1:0]  STEP_P      = POS_W'(STEP);
    localparam logic [ROOM_W-1:0] LAST_ROOM   = ROOM_W'(NUM_ROOMS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(MOVE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(RESPAWN_CYC);

    typedef enum logic [1:0] {S_PLAY, S_RESPAWN, S_WON} state_t;

    state_t               state_reg, state_next;
    logic [HOLD_W-1:0]    hold_reg, hold_next;
    logic [TICK_W-1:0]    tick_reg, tick_next;
    logic [POS_W-1:0]     x_reg, x_next;
    logic [POS_W-1:0]     y_reg, y_next;
    logic [POS_W-1:0]     px_reg, px_next;
    logic [POS_W-1:0]     py_reg, py_next;
    logic [ROOM_W-1:0]    room_reg, room_next;
    logic [NUM_ROOMS-1:0] active_reg, active_next;
    logic                 room_change_reg, room_change_next;
    logic                 won_reg, won_next;

    logic                 step_tick;
    logic                 any_press;
    logic [POS_W-1:0]     x_left;
    logic [POS_W-1:0]     x_right;

    assign step_tick = (tick_reg == TICK_LAST);
    assign any_press = !(bus.u_arr && bus.d_arr && bus.l_arr && bus.r_arr);
    assign x_left    = ((x_reg - STEP_P) < X_MIN_P) ? X_MIN_P : (x_reg - STEP_P);
    assign x_right   = ((x_reg + STEP_P) > X_MAX_P) ? X_MAX_P : (x_reg + STEP_P);

    // One-hot room decode of the next room index.
    for (genvar gi = 0; gi < NUM_ROOMS; gi++) begin : g_onehot
        assign active_next[gi] = (room_next == ROOM_W'(gi));
    end

    assign room_change_next = (room_next != room_reg);
    assign won_next         = (state_next == S_WON);

    // Next state and datapath, highest-priority event first.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        tick_next  = '0;
        x_next     = x_reg;
        y_next     = y_reg;
        px_next    = px_reg;
        py_next    = py_reg;
        room_next  = room_reg;
        if (bus.win_flag || state_reg == S_WON) begin
            state_next = S_WON;
        end else if (|bus.death_flag) begin
            state_next = S_RESPAWN;
            hold_next  = HOLD_INIT;
            room_next  = '0;
            x_next     = INIT_X_P;
            y_next     = INIT_Y_P;
            px_next    = INIT_X_P;
            py_next    = INIT_Y_P;
        end else if (state_reg == S_RESPAWN) begin
            if (hold_reg == '0) begin
                state_next = S_PLAY;
            end else begin
                hold_next = hold_reg - 1'b1;
            end
        end else begin
            tick_next = step_tick ? '0 : tick_reg + 1'b1;
            if (bus.coll_miner) begin
                if (MINER_ADV[room_reg] && room_reg != LAST_ROOM) begin
                    room_next = room_reg + 1'b1;
                end
                state_next = S_RESPAWN;
                hold_next  = HOLD_INIT;
                tick_next  = '0;
                x_next     = INIT_X_P;
                y_next     = INIT_Y_P;
                px_next    = INIT_X_P;
                py_next    = INIT_Y_P;
            end else if (y_reg >= Y_BOT_P) begin
                if (DOWN_EXIT[room_reg] && room_reg != LAST_ROOM) begin
                    room_next = room_reg + 1'b1;
                    y_next    = ENTRY_TOP_P;
                end else begin
                    y_next = Y_BOT_P - 1'b1;
                end
                px_next = x_reg;
                py_next = y_next;
            end else if (y_reg <= Y_TOP_P) begin
                if (UP_EXIT[room_reg] && room_reg != '0) begin
                    room_next = room_reg - 1'b1;
                    y_next    = ENTRY_BOT_P;
                end else begin
                    y_next = Y_TOP_P + 1'b1;
                end
                px_next = x_reg;
                py_next = y_next;
            end else if (bus.collision) begin
                // Undo the last step; the wall was entered by it.
                x_next = px_reg;
                y_next = py_reg;
            end else if (step_tick && any_press) begin
                px_next = x_reg;
                py_next = y_reg;
                if (!bus.u_arr) begin
                    y_next = y_reg - STEP_P;
                end else if (!bus.d_arr) begin
                    y_next = y_reg + STEP_P;
                end else if (!bus.l_arr) begin
                    x_next = x_left;
                end else begin
                    x_next = x_right;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_char or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_RESPAWN;
            hold_reg        <= HOLD_INIT;
            tick_reg        <= '0;
            x_reg           <= INIT_X_P;
            y_reg           <= INIT_Y_P;
            px_reg          <= INIT_X_P;
            py_reg          <= INIT_Y_P;
            room_reg        <= '0;
            active_reg      <= NUM_ROOMS'(1);
            room_change_reg <= 1'b0;
            won_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_reg        <= hold_next;
            tick_reg        <= tick_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            px_reg          <= px_next;
            py_reg          <= py_next;
            room_reg        <= room_next;
            active_reg      <= active_next;
            room_change_reg <= room_change_next;
            won_reg         <= won_next;
        end
    end

    assign bus.char_pos_x  = x_reg;
    assign bus.char_pos_y  = y_reg;
    assign bus.active      = active_reg;
    assign bus.room_idx    = room_reg;
    assign bus.room_change = room_change_reg;
    assign bus.won         = won_reg;
endmodule

// File: doc/movement_ctrl.md
# movement_ctrl

Parametrised hero movement controller: it turns active-low arrow buttons into a registered character position and a one-hot active-room vector. It generalises the fixed 16-room hero controller with configurable room count, geometry, step size and step rate, and a per-room exit map. It adds clean collision rollback, a respawn hold state and a win freeze. It sits between the button inputs and the sprite/room renderers and the collision and miner detectors.

## Interface
- POS_W, 10, position width in pixels
- NUM_ROOMS, 16, number of rooms; width of `active` and `death_flag`
- INIT_X / INIT_Y, 175 / 100, spawn position in room 0
- X_MIN / X_MAX, 8 / 630, horizontal clamp limits, inclusive
- Y_TOP / Y_BOT, 40 / 400, vertical edge thresholds
- ENTRY_TOP / ENTRY_BOT, 50 / 350, y after entering a room via its top edge / bottom edge
- STEP, 1, pixels moved per step tick
- MOVE_DIV, 1, clocks per step tick (1 = every clock)
- RESPAWN_CYC, 4, input-ignore cycles after death or miner rescue
- DOWN_EXIT, all ones, bit r=1: bottom edge of room r leads to room r+1
- UP_EXIT, all ones except bit 0, bit r=1: top edge of room r leads to room r-1
- MINER_ADV, bits 1 and 5, bit r=1: miner rescue in room r advances to room r+1
- Constraints: STEP < Y_TOP; STEP < X_MIN; Y_BOT + STEP < 2^POS_W; X_MAX + STEP < 2^POS_W
- clk_char  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- u_arr, d_arr, l_arr, r_arr  in  1 each  arrow buttons, active-low
- collision  in  1  character overlaps a wall at the current position
- coll_miner  in  1  character touches the miner
- death_flag  in  NUM_ROOMS  any nonzero bit = death
- win_flag  in  1  game won
- char_pos_x, char_pos_y  out  POS_W each  character position
- active  out  NUM_ROOMS  one-hot current room
- room_idx  out  $clog2(NUM_ROOMS)  binary index of the current room
- room_change  out  1  one-cycle pulse when the room changes
- won  out  1  high in the WON state

## Operation
- FSM states: PLAY, RESPAWN, WON.
- Reset: state = RESPAWN, hold counter = RESPAWN_CYC, x = INIT_X, y = INIT_Y, active = 1, room_idx = 0, room_change = 0, won = 0, prev = spawn position, tick counter = 0.
- Step tick:
  - Tick counter counts 0..MOVE_DIV-1 and asserts a tick when it reaches MOVE_DIV-1.
  - The counter runs only in PLAY; it is cleared in RESPAWN and WON.
- Move in PLAY, on a tick with collision = 0:
  - Only the highest-priority pressed button acts; priority is up > down > left > right.
  - Up: y -= STEP. Down: y += STEP. Left: x -= STEP. Right: x += STEP.
  - Before moving, prev_x/prev_y are loaded with the current position.
  - Diagonal presses never move both axes in one step.
- Collision in PLAY: when collision = 1, x/y are restored to prev_x/prev_y on that cycle, independent of the tick. No movement happens that cycle.
- X clamp: x < X_MIN → x = X_MIN; x > X_MAX → x = X_MAX.
- Bottom edge, y ≥ Y_BOT:
  - If DOWN_EXIT[room] is set and room < NUM_ROOMS-1: room += 1, y = ENTRY_TOP.
  - Otherwise y = Y_BOT - 1.
- Top edge, y ≤ Y_TOP:
  - If UP_EXIT[room] is set and room > 0: room -= 1, y = ENTRY_BOT.
  - Otherwise y = Y_TOP + 1.
  - x is unchanged on any room transition. prev is set to the new position.
- Miner rescue, coll_miner = 1 in PLAY:
  - If MINER_ADV[room] is set and room < NUM_ROOMS-1, room += 1.
  - Position is set to INIT_X/INIT_Y and the FSM goes to RESPAWN.
- Death, any death_flag bit set in PLAY or RESPAWN: room = 0, position = spawn, hold counter reloaded, FSM goes to RESPAWN.
- RESPAWN: buttons, collision and coll_miner are ignored. The hold counter decrements each clock; at 0 the FSM goes to PLAY.
- WON: entered from any state when win_flag = 1. Position and room freeze and won = 1. Only rst_n exits WON.
- Same-cycle priority, highest first: reset > win_flag > death > coll_miner > edge transition > collision rollback > move.
- active is always exactly one-hot and equal to 1 << room_idx.

## Timing
- All outputs are registered. An input sampled at edge N is reflected on the outputs after edge N.
- Move latency is 1 clock from the tick. Rollback latency is 1 clock from collision.
- Edge checks use the registered position. An edge crossing therefore resolves on the clock after the step that crossed it, so the overshoot is at most STEP pixels for 1 cycle.
- room_change is high for exactly the one cycle after any room update (edge, miner, or death from room ≠ 0).
- RESPAWN lasts exactly RESPAWN_CYC+1 clocks.
- An rst_n assertion mid-step takes effect immediately and asynchronously.

## Test plan
- Reset, then hold d_arr = 0 with MOVE_DIV = 1 → y increments 100, 101, … from the first PLAY cycle. At y = 400 the next cycle gives room 1, y = 50, active = 0x0002, room_change pulses once.
- In room 1, hold u_arr = 0 until y = 40 → room 0, y = 350. Then in room 0 with u_arr held to y = 40 → y = 41, room stays 0, no room_change.
- At (200,200), press r_arr for one tick, then assert collision → x goes to 201, then back to 200. Press u_arr and r_arr together → only y changes.
- Room 1 with coll_miner = 1 → room 2, position (175,100), pressed buttons ignored for 5 clocks. Room 3 with coll_miner = 1 → room stays 3 and respawns.
- death_flag = 0x0100 in the same cycle as coll_miner and an edge crossing → room 0, spawn position, RESPAWN. Then win_flag = 1 → won = 1 and held arrows leave position and active unchanged.
- MOVE_DIV = 4: hold l_arr → x decrements once per 4 clocks and clamps at X_MIN. rst_n low mid-run → outputs return to reset values immediately.
